// File: rtl/ifft_8pt_iter.sv
// 8-point radix-2 DIT inverse FFT, signed fixed point, one shared butterfly
// time-multiplexed over an 8-entry complex register file (3 stages x 4 butterflies).
module ifft_8pt_iter #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int TW_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [8*DATA_W-1:0] X_R_i,
   input  logic [8*DATA_W-1:0] X_I_i,
   output logic [8*DATA_W-1:0] x_R_o,
   output logic [8*DATA_W-1:0] x_I_o,
   output logic                valid_o,
   output logic                busy_o
);

   localparam int SUM_W   = DATA_W + 2;
   localparam int PROD_W  = DATA_W + TW_W + 1;
   localparam int TW_FRAC = TW_W - 2;

   localparam logic signed [PROD_W-1:0] ROUND   = PROD_W'(1) <<< (TW_FRAC - 1);
   localparam logic signed [SUM_W-1:0]  SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0]  SAT_MIN = -SUM_W'(1 << (DATA_W - 1));

   // The sample format only matters to the user; reject nonsensical settings early.
   if (FRAC_W >= DATA_W) begin : gBadFrac
      $error("FRAC_W must be smaller than DATA_W");
   end

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state_q, state_d;
   logic [1:0] stage_q, stage_d;
   logic [1:0] bfly_q, bfly_d;
   logic       busy_q, busy_d;
   logic       valid_q, valid_d;
   logic [8*DATA_W-1:0] xR_q, xR_d;
   logic [8*DATA_W-1:0] xI_q, xI_d;

   logic signed [DATA_W-1:0] workR_q [8];
   logic signed [DATA_W-1:0] workI_q [8];
   logic signed [DATA_W-1:0] workR_d [8];
   logic signed [DATA_W-1:0] workI_d [8];

   logic [2:0] span, low, topIdx, botIdx;
   logic [1:0] twIdx;
   logic signed [TW_W-1:0]   wR, wI;
   logic signed [DATA_W-1:0] topR, topI, botR, botI;
   logic signed [PROD_W-1:0] prodR, prodI, rndR, rndI;
   logic signed [SUM_W-1:0]  tR, tI, sumR, sumI, difR, difI;
   logic signed [DATA_W-1:0] newTopR, newTopI, newBotR, newBotI;

   function automatic logic [2:0] rev3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > SAT_MAX) begin
         return DATA_W'(SAT_MAX);
      end else if (v < SAT_MIN) begin
         return DATA_W'(SAT_MIN);
      end
      return DATA_W'(v);
   endfunction

   // Butterfly addressing: pairs are span apart, grouped in blocks of 2*span.
   always_comb begin
      span   = 3'b001 << stage_q;
      low    = {1'b0, bfly_q} & (span - 3'd1);
      topIdx = (({1'b0, bfly_q} >> stage_q) << (stage_q + 2'd1)) + low;
      botIdx = topIdx + span;
      twIdx  = 2'(low << (2'd2 - stage_q));
   end

   // Inverse twiddles e^{+j*2*pi*k/8} in Q2.14.
   always_comb begin
      wR = '0;
      wI = '0;
      case (twIdx)
         2'd0: begin wR = TW_W'(16384);  wI = TW_W'(0);     end
         2'd1: begin wR = TW_W'(11585);  wI = TW_W'(11585); end
         2'd2: begin wR = TW_W'(0);      wI = TW_W'(16384); end
         default: begin wR = TW_W'(-11585); wI = TW_W'(11585); end
      endcase
   end

   always_comb begin
      topR  = workR_q[topIdx];
      topI  = workI_q[topIdx];
      botR  = workR_q[botIdx];
      botI  = workI_q[botIdx];
      prodR = PROD_W'(botR) * PROD_W'(wR) - PROD_W'(botI) * PROD_W'(wI);
      prodI = PROD_W'(botR) * PROD_W'(wI) + PROD_W'(botI) * PROD_W'(wR);
      rndR  = (prodR + ROUND) >>> TW_FRAC;
      rndI  = (prodI + ROUND) >>> TW_FRAC;
      tR    = SUM_W'(rndR);
      tI    = SUM_W'(rndI);
      sumR  = SUM_W'(topR) + tR;
      sumI  = SUM_W'(topI) + tI;
      difR  = SUM_W'(topR) - tR;
      difI  = SUM_W'(topI) - tI;
      newTopR = sat(sumR >>> 1);
      newTopI = sat(sumI >>> 1);
      newBotR = sat(difR >>> 1);
      newBotI = sat(difI >>> 1);
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      bfly_d  = bfly_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      xR_d    = xR_q;
      xI_d    = xI_q;
      for (int k = 0; k < 8; k++) begin
         workR_d[k] = workR_q[k];
         workI_d[k] = workI_q[k];
      end
      case (state_q)
         IDLE: begin
            if (start_i) begin
               for (int k = 0; k < 8; k++) begin
                  workR_d[rev3(3'(k))] = X_R_i[k*DATA_W +: DATA_W];
                  workI_d[rev3(3'(k))] = X_I_i[k*DATA_W +: DATA_W];
               end
               busy_d  = 1'b1;
               stage_d = '0;
               bfly_d  = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            workR_d[topIdx] = newTopR;
            workI_d[topIdx] = newTopI;
            workR_d[botIdx] = newBotR;
            workI_d[botIdx] = newBotI;
            bfly_d = bfly_q + 2'd1;
            if (bfly_q == 2'd3) begin
               if (stage_q == 2'd2) begin
                  state_d = DONE;
               end else begin
                  stage_d = stage_q + 2'd1;
               end
            end
         end
         DONE: begin
            for (int k = 0; k < 8; k++) begin
               xR_d[k*DATA_W +: DATA_W] = workR_q[k];
               xI_d[k*DATA_W +: DATA_W] = workI_q[k];
            end
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         stage_q <= '0;
         bfly_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         xR_q    <= '0;
         xI_q    <= '0;
         for (int k = 0; k < 8; k++) begin
            workR_q[k] <= '0;
            workI_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         xR_q    <= xR_d;
         xI_q    <= xI_d;
         for (int k = 0; k < 8; k++) begin
            workR_q[k] <= workR_d[k];
            workI_q[k] <= workI_d[k];
         end
      end
   end

   assign x_R_o   = xR_q;
   assign x_I_o   = xI_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_ifft_8pt_iter.sv
// Scoreboard bench for ifft_8pt_iter: directed spectra with hand-computed time
// samples are queued at issue time; a negedge monitor pops and compares on valid_o.
module tb_ifft_8pt_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_i;
   logic [127:0] specR;
   logic [127:0] specI;
   logic [127:0] timeR;
   logic [127:0] timeI;
   logic         valid_o;
   logic         busy_o;

   typedef struct {
      logic [127:0] r;
      logic [127:0] i;
      string        name;
   } frame_t;

   frame_t expQ[$];
   int     nChecks = 0;
   int     nFails  = 0;
   frame_t monFrame;

   ifft_8pt_iter dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .X_R_i   (specR),
      .X_I_i   (specI),
      .x_R_o   (timeR),
      .x_I_o   (timeI),
      .valid_o (valid_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] pack8(input logic [15:0] s0, s1, s2, s3, s4, s5, s6, s7);
      return {s7, s6, s5, s4, s3, s2, s1, s0};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one frame at the next rising edge; optionally queue its expected result.
   task automatic applyStimulus(input logic [127:0] inR, input logic [127:0] inI,
                                input logic [127:0] expR, input logic [127:0] expI,
                                input string name, input bit expectIt);
      frame_t f;
      specR   = inR;
      specI   = inI;
      start_i = 1'b1;
      if (expectIt) begin
         f.r = expR;
         f.i = expI;
         f.name = name;
         expQ.push_back(f);
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic watchFrame(input string name);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s busy E%0d", name, k), 128'(busy_o), 128'(k <= 12));
         checkOutput($sformatf("%s valid E%0d", name, k), 128'(valid_o), 128'(k == 13));
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (valid_o === 1'b1) begin
         if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected valid_o: got 1, expected 0");
         end else begin
            monFrame = expQ.pop_front();
            for (int n = 0; n < 8; n++) begin
               checkOutput($sformatf("%s x%0d re", monFrame.name, n),
                           128'(timeR[n*16 +: 16]), 128'(monFrame.r[n*16 +: 16]));
               checkOutput($sformatf("%s x%0d im", monFrame.name, n),
                           128'(timeI[n*16 +: 16]), 128'(monFrame.i[n*16 +: 16]));
            end
         end
      end
   end

   initial begin
      logic [127:0] allR, x0R, x1R, x2R, x3I, expX1R, expX1I, expX2R, expX2I;
      logic [127:0] expX3R, expX3I, ones, halfI;
      int validSeen;

      allR   = pack8(16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800);
      x0R    = pack8(16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      x1R    = pack8(16'h0, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      x2R    = pack8(16'h0, 16'h0, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      x3I    = pack8(16'h0, 16'h0, 16'h0, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0);
      ones   = pack8(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      halfI  = pack8(16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080);
      expX2R = pack8(16'h0100, 16'h0, 16'hFF00, 16'h0, 16'h0100, 16'h0, 16'hFF00, 16'h0);
      expX2I = pack8(16'h0, 16'h0100, 16'h0, 16'hFF00, 16'h0, 16'h0100, 16'h0, 16'hFF00);
      expX1R = pack8(16'h0100, 16'h00B5, 16'h0, 16'hFF4B, 16'hFF00, 16'hFF4B, 16'h0, 16'h00B5);
      expX1I = pack8(16'h0, 16'h00B5, 16'h0100, 16'h00B5, 16'h0, 16'hFF4B, 16'hFF00, 16'hFF4B);
      expX3R = pack8(16'h0, 16'hFF4B, 16'h0100, 16'hFF4B, 16'h0, 16'h00B5, 16'hFF00, 16'h00B5);
      expX3I = pack8(16'h0100, 16'hFF4B, 16'h0, 16'h00B5, 16'hFF00, 16'h00B5, 16'h0, 16'hFF4B);

      rst     = 1'b1;
      start_i = 1'b0;
      specR   = '0;
      specI   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset x_R_o", timeR, 128'h0);
      checkOutput("reset x_I_o", timeI, 128'h0);
      checkOutput("reset valid_o", 128'(valid_o), 128'h0);
      checkOutput("reset busy_o", 128'(busy_o), 128'h0);
      @(posedge clk);
      #1;

      $display("[TB] directed frames");
      applyStimulus(allR, '0, pack8(16'h0800, 0, 0, 0, 0, 0, 0, 0), '0, "allDC", 1'b1);
      watchFrame("allDC");
      applyStimulus(x0R, '0, ones, '0, "X0", 1'b1);
      watchFrame("X0");
      applyStimulus('0, pack8(16'h0400, 0, 0, 0, 0, 0, 0, 0), '0, halfI, "X0imag", 1'b1);
      watchFrame("X0imag");
      applyStimulus('0, x3I, expX3R, expX3I, "X3imag", 1'b1);
      watchFrame("X3imag");

      $display("[TB] ignored starts and back-to-back frames");
      applyStimulus(x2R, '0, expX2R, expX2I, "X2", 1'b1);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         checkOutput($sformatf("X2 busy E%0d", k), 128'(busy_o), 128'(k <= 12));
         checkOutput($sformatf("X2 valid E%0d", k), 128'(valid_o), 128'(k == 13));
         if (k == 13) begin
            applyStimulus(x1R, '0, expX1R, expX1I, "X1", 1'b1);
         end else begin
            start_i = (k == 4 || k == 12);
            @(posedge clk);
            #1;
            start_i = 1'b0;
         end
      end
      watchFrame("X1");

      $display("[TB] reset mid-frame");
      applyStimulus(allR, '0, '0, '0, "aborted", 1'b0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         checkOutput($sformatf("aborted busy E%0d", k), 128'(busy_o), 128'h1);
         if (k == 6) rst = 1'b1;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort x_R_o", timeR, 128'h0);
      checkOutput("abort x_I_o", timeI, 128'h0);
      checkOutput("abort valid_o", 128'(valid_o), 128'h0);
      checkOutput("abort busy_o", 128'(busy_o), 128'h0);
      validSeen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (valid_o === 1'b1) validSeen++;
      end
      checkOutput("abort no valid", 128'(validSeen), 128'h0);
      @(posedge clk);
      #1;
      applyStimulus(x0R, '0, ones, '0, "afterReset", 1'b1);
      watchFrame("afterReset");

      @(negedge clk);
      checkOutput("scoreboard drained", 128'(expQ.size()), 128'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
